// File: rtl/stm_focus_writer.sv
// Focus-STM sample writer: packs 4x16-bit CPU words into 64-bit focus entries and streams them to BRAM.
// Optional CHECKSUM accumulator enabled by defining STM_WRITER_CHECKSUM_EN.
module stm_focus_writer #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  SEGMENT_IN,
  input  logic [15:0]           COUNT,
  input  logic [15:0]           DIN,
  input  logic                  DIN_VALID,
  output logic                  DIN_READY,
  output logic                  WE,
  output logic [ADDR_WIDTH:0]   WADDR,
  output logic [63:0]           WDATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [15:0]           CYCLE,
  output logic                  ERR,
  output logic [15:0]           CHECKSUM
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

  localparam logic [16:0] MAX_COUNT = 17'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] IDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic                  seg_q, seg_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [1:0]            k_q, k_d;
  logic [15:0]           w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH:0]   waddr_q, waddr_d;
  logic [63:0]           wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [15:0]           cycle_q, cycle_d;
  logic                  err_q, err_d;

  logic                  hs;
  logic                  count_ok;
  logic                  start_acc;
  logic [ADDR_WIDTH:0]   idx_inc;

  assign hs        = (state_q == COLLECT) && DIN_VALID;
  assign count_ok  = (COUNT != 16'd0) && ({1'b0, COUNT} <= MAX_COUNT);
  assign start_acc = (state_q == IDLE) && START && count_ok;
  assign idx_inc   = idx_q + IDX_ONE;

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    count_d = count_q;
    idx_d   = idx_q;
    k_d     = k_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    cycle_d = cycle_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          if (count_ok) begin
            seg_d   = SEGMENT_IN;
            count_d = COUNT[ADDR_WIDTH:0];
            idx_d   = '0;
            k_d     = 2'd0;
            state_d = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (hs) begin
          k_d = k_q + 2'd1;
          case (k_q)
            2'd0: w0_d = DIN;
            2'd1: w1_d = DIN;
            2'd2: w2_d = DIN;
            default: begin
              // w3 comes straight from DIN; bits [15:14] are dropped
              we_d    = 1'b1;
              waddr_d = {seg_q, idx_q[ADDR_WIDTH-1:0]};
              wdata_d = {2'b00, DIN[13:6], DIN[5:0], w2_q[15:4], w2_q[3:0],
                         w1_q[15:2], w1_q[1:0], w0_q};
              state_d = WRITE;
            end
          endcase
        end
      end
      WRITE: begin
        idx_d = idx_inc;
        if (idx_inc == count_q) begin
          done_d  = 1'b1;
          cycle_d = 16'(count_q) - 16'd1;
          state_d = FINISH;
        end else begin
          k_d     = 2'd0;
          state_d = COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      seg_q   <= 1'b0;
      count_q <= '0;
      idx_q   <= '0;
      k_q     <= 2'd0;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cycle_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cycle_q <= cycle_d;
      err_q   <= err_d;
    end
  end

`ifdef STM_WRITER_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_acc)
      csum_d = 16'd0;
    else if (hs)
      csum_d = csum_q ^ DIN;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign CHECKSUM = csum_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign CHECKSUM = 16'd0;
`endif

  assign DIN_READY = (state_q == COLLECT);
  assign WE        = we_q;
  assign WADDR     = waddr_q;
  assign WDATA     = wdata_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign CYCLE     = cycle_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_stm_focus_writer.sv
// Scoreboard bench for stm_focus_writer: expected writes/completions queued at stimulus time,
// popped and compared by a negedge monitor.
module tb_stm_focus_writer;

  localparam int AW = 13;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          START = 1'b0;
  logic          SEGMENT_IN = 1'b0;
  logic [15:0]   COUNT = '0;
  logic [15:0]   DIN = '0;
  logic          DIN_VALID = 1'b0;
  logic          DIN_READY, WE, BUSY, DONE, ERR;
  logic [AW:0]   WADDR;
  logic [63:0]   WDATA;
  logic [15:0]   CYCLE, CHECKSUM;

  stm_focus_writer #(.ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .SEGMENT_IN(SEGMENT_IN), .COUNT(COUNT),
    .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY), .WE(WE), .WADDR(WADDR),
    .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .CYCLE(CYCLE), .ERR(ERR), .CHECKSUM(CHECKSUM)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [AW:0] a; logic [63:0] d; } wr_t;
  typedef struct { logic [15:0] cyc; logic [15:0] cs; } dn_t;

  wr_t         wq[$];
  dn_t         dq[$];
  logic [15:0] stim[$];
  int          checks = 0;
  int          errors = 0;
  logic        we_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [15:0] w0, w1, w2, w3);
    logic [17:0] x, y, z;
    logic [7:0]  inten;
    x = {w1[1:0], w0};
    y = {w2[3:0], w1[15:2]};
    z = {w3[5:0], w2[15:4]};
    inten = w3[13:6];
    return {2'b00, inten, z, y, x};
  endfunction

  // monitor
  always @(negedge CLK) begin
    if (RST_N) begin
      if (WE) begin
        chk("ready_low_in_write", {63'd0, DIN_READY}, 64'd0);
        if (wq.size() == 0) begin
          chk("unexpected_we", {50'd0, WADDR}, 64'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("waddr", {50'd0, WADDR}, {50'd0, e.a});
          chk("wdata", WDATA, e.d);
        end
      end
      if (DONE) begin
        chk("done_after_we", {63'd0, we_prev}, 64'd1);
        chk("busy_at_done", {63'd0, BUSY}, 64'd1);
        if (dq.size() == 0) begin
          chk("unexpected_done", {48'd0, CYCLE}, 64'hFFFF_FFFF);
        end else begin
          dn_t e;
          e = dq.pop_front();
          chk("cycle", {48'd0, CYCLE}, {48'd0, e.cyc});
          chk("checksum", {48'd0, CHECKSUM}, {48'd0, e.cs});
        end
      end
      we_prev = WE;
    end else begin
      we_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, {63'd0, DIN_READY}, 64'd0);
    chk({tag, "_we"},    {63'd0, WE}, 64'd0);
    chk({tag, "_waddr"}, {50'd0, WADDR}, 64'd0);
    chk({tag, "_wdata"}, WDATA, 64'd0);
    chk({tag, "_busy"},  {63'd0, BUSY}, 64'd0);
    chk({tag, "_done"},  {63'd0, DONE}, 64'd0);
    chk({tag, "_cycle"}, {48'd0, CYCLE}, 64'd0);
    chk({tag, "_err"},   {63'd0, ERR}, 64'd0);
    chk({tag, "_csum"},  {48'd0, CHECKSUM}, 64'd0);
  endtask

  task automatic fill_seq(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(16'(i + 1));
  endtask

  task automatic fill_rand(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(16'($urandom));
  endtask

  // mode: 0 back-to-back, 1 valid toggles every other cycle, 2 random valid
  task automatic run_session(input bit seg, input int cnt, input int mode);
    dn_t  dn;
    logic [15:0] cs;
    int   i, cyc, budget, t;
    logic hs;
    cs = 16'd0;
    for (int e = 0; e < cnt; e++) begin
      wr_t w;
      w.a = {seg, AW'(e)};
      w.d = pack(stim[4*e], stim[4*e+1], stim[4*e+2], stim[4*e+3]);
      wq.push_back(w);
      cs = cs ^ stim[4*e] ^ stim[4*e+1] ^ stim[4*e+2] ^ stim[4*e+3];
    end
    dn.cyc = 16'(cnt - 1);
`ifdef STM_WRITER_CHECKSUM_EN
    dn.cs = cs;
`else
    dn.cs = 16'd0;
`endif
    dq.push_back(dn);
    START = 1'b1; SEGMENT_IN = seg; COUNT = 16'(cnt);
    tick();
    START = 1'b0;
    chk("busy_after_start", {63'd0, BUSY}, 64'd1);
    chk("ready_after_start", {63'd0, DIN_READY}, 64'd1);
    i = 0; cyc = 0; budget = cnt * 24 + 100;
    while (i < 4 * cnt && cyc < budget) begin
      DIN = stim[i];
      case (mode)
        0:       DIN_VALID = 1'b1;
        1:       DIN_VALID = (cyc % 2 == 0);
        default: DIN_VALID = 1'($urandom_range(0, 1));
      endcase
      @(negedge CLK);
      hs = DIN_VALID && DIN_READY;
      tick();
      if (hs) i++;
      cyc++;
    end
    DIN_VALID = 1'b0;
    if (i < 4 * cnt) chk("feed_timeout", 64'(i), 64'(4 * cnt));
    t = 0;
    while (BUSY && t < 50) begin
      tick();
      t++;
    end
    chk("busy_cleared", {63'd0, BUSY}, 64'd0);
    chk("writes_drained", 64'(wq.size()), 64'd0);
    chk("done_drained", 64'(dq.size()), 64'd0);
  endtask

  task automatic bad_start(input logic [15:0] cnt, input string tag);
    START = 1'b1; COUNT = cnt; SEGMENT_IN = 1'b0;
    tick();
    START = 1'b0;
    chk({tag, "_err"}, {63'd0, ERR}, 64'd1);
    chk({tag, "_busy"}, {63'd0, BUSY}, 64'd0);
    tick();
    chk({tag, "_err_pulse"}, {63'd0, ERR}, 64'd0);
    chk({tag, "_busy2"}, {63'd0, BUSY}, 64'd0);
  endtask

  initial begin
    #2;
    check_reset("rst");
    repeat (2) tick();
    RST_N = 1'b1;
    tick();

    fill_seq(8);
    run_session(1'b1, 2, 0);
    chk("cycle_hold", {48'd0, CYCLE}, 64'd1);

    fill_seq(8);
    run_session(1'b1, 2, 1);

    bad_start(16'd0, "cnt0");
    bad_start(16'd8193, "cnt8193");
    bad_start(16'hFFFF, "cntmax");

    fill_rand(20);
    run_session(1'b0, 5, 2);

    fill_rand(4 * 8192);
    run_session(1'b0, 8192, 0);
    chk("cycle_full", {48'd0, CYCLE}, 64'd8191);

    // stray START mid-session, then reset
    START = 1'b1; SEGMENT_IN = 1'b1; COUNT = 16'd3;
    tick();
    START = 1'b0;
    DIN_VALID = 1'b1; DIN = 16'hAAAA;
    repeat (2) tick();
    DIN_VALID = 1'b0;
    START = 1'b1; COUNT = 16'd0; SEGMENT_IN = 1'b0;
    tick();
    START = 1'b0;
    chk("stray_err", {63'd0, ERR}, 64'd0);
    chk("stray_busy", {63'd0, BUSY}, 64'd1);
    chk("stray_ready", {63'd0, DIN_READY}, 64'd1);
    RST_N = 1'b0;
    #1;
    check_reset("mid_rst");
    wq.delete();
    dq.delete();
    tick();
    RST_N = 1'b1;
    tick();

    fill_rand(12);
    run_session(1'b1, 3, 0);

    stim.delete();
    stim.push_back(16'h1234); stim.push_back(16'h00FF);
    stim.push_back(16'hFFFF); stim.push_back(16'h0000);
    run_session(1'b0, 1, 1);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
